booth_multiplier_withregs: RTL and testbench

//   Registered 32x32 signed multiplier built on radix-2 Booth recoding. Operands are

---
 rtl/booth_multiplier_withregs_pkg.sv | 7 +
 rtl/booth_mult_core.sv | 37 +++
 rtl/booth_multiplier_withregs.sv | 50 +++++
 tb/tb_booth_multiplier_withregs.sv | 127 ++++++++++++
 4 files changed

// File: rtl/booth_multiplier_withregs_pkg.sv
// rtl/booth_multiplier_withregs_pkg.sv - shared widths for the registered Booth multiplier
package booth_multiplier_withregs_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int PROD_W    = 2 * WIDTH_DEF;

endpackage

// File: rtl/booth_mult_core.sv
// rtl/booth_mult_core.sv - combinational radix-2 Booth multiplier, full-width signed product
module booth_mult_core
  import booth_multiplier_withregs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]  a_ext;
  logic [WIDTH:0] b_pad;
  logic [PW-1:0]  pp  [WIDTH];
  logic [PW-1:0]  sum [WIDTH+1];

  // Implicit zero below the multiplier LSB starts the Booth pair scan.
  assign a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_pad  = {b, 1'b0};
  assign sum[0] = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic [1:0]    sel;
    logic [PW-1:0] shifted;

    assign sel      = {b_pad[i+1], b_pad[i]};
    assign shifted  = a_ext << i;
    assign pp[i]    = (sel == 2'b01) ? shifted :
                      (sel == 2'b10) ? (~shifted + 1'b1) : '0;
    assign sum[i+1] = sum[i] + pp[i];
  end

  assign product = sum[WIDTH];

endmodule

// File: rtl/booth_multiplier_withregs.sv
// rtl/booth_multiplier_withregs.sv - two-stage registered signed multiplier with 32-bit overflow flag
module booth_multiplier_withregs
  import booth_multiplier_withregs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    result_q, result_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH:0]   upper;

  booth_mult_core #(.WIDTH(WIDTH)) u_core (
    .a       (a_q),
    .b       (b_q),
    .product (result_d)
  );

  // Product fits in WIDTH-bit signed only when bits [PW-1:WIDTH-1] are a pure sign extension.
  assign upper      = result_d[PW-1:WIDTH-1];
  assign overflow_d = !((&upper) || !(|upper));

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else if (en) begin
      a_q        <= a;
      b_q        <= b;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_booth_multiplier_withregs.sv
// tb/tb_booth_multiplier_withregs.sv - randomized and directed checks against an arithmetic reference
module tb_booth_multiplier_withregs;

  logic [31:0] a, b;
  logic        clk, reset, en;
  logic [63:0] result;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  int     m_a, m_b;
  longint m_res;
  logic   m_ovf;

  booth_multiplier_withregs dut (
    .a        (a),
    .b        (b),
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .result   (result),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: an accepted edge publishes the product of the operands accepted one edge earlier.
  task automatic step(input logic [31:0] ai, input logic [31:0] bi, input logic eni, input logic rsti);
    longint p;
    a = ai; b = bi; en = eni; reset = rsti;
    @(posedge clk);
    if (rsti) begin
      m_a = 0; m_b = 0; m_res = 0; m_ovf = 1'b0;
    end else if (eni) begin
      p     = longint'(m_a) * longint'(m_b);
      m_res = p;
      m_ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      m_a   = int'(ai);
      m_b   = int'(bi);
    end
    #1;
    check("result", result, m_res);
    check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'($signed($urandom_range(0, 40)) - 20);
      2:       return 32'h0001_0000;
      default: return $urandom();
    endcase
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        ovf;
  } vec_t;

  vec_t dir[10];

  initial begin
    m_a = 0; m_b = 0; m_res = 0; m_ovf = 1'b0;
    a = '0; b = '0; en = 1'b0; reset = 1'b1;

    step(32'd0, 32'd0, 1'b0, 1'b1);
    step(32'd0, 32'd0, 1'b1, 1'b1);
    check("reset_result", result, 64'd0);
    check("reset_ovf", {63'd0, overflow}, 64'd0);

    dir[0] = '{32'd5,          -32'sd7,       -64'sd35,                1'b0};
    dir[1] = '{32'd2,          32'd3,         64'd6,                   1'b0};
    dir[2] = '{-32'sd12,       -32'sd4,       64'd48,                  1'b0};
    dir[3] = '{-32'sd9,        32'd5,         -64'sd45,                1'b0};
    dir[4] = '{32'd11,         32'd0,         64'd0,                   1'b0};
    dir[5] = '{32'd10,         32'd1,         64'd10,                  1'b0};
    dir[6] = '{32'd4,          32'd6,         64'd24,                  1'b0};
    dir[7] = '{-32'sd1,        -32'sd7,       64'd7,                   1'b0};
    dir[8] = '{32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1};
    dir[9] = '{32'd65536,      32'd65536,     64'h1_0000_0000,         1'b1};

    foreach (dir[i]) begin
      step(dir[i].a, dir[i].b, 1'b1, 1'b0);
      step(32'd0, 32'd0, 1'b1, 1'b0);
      check("dir_result", result, dir[i].p);
      check("dir_ovf", {63'd0, overflow}, {63'd0, dir[i].ovf});
    end

    // Product exactly -2^31 is still representable.
    step(32'h8000_0000, 32'd1, 1'b1, 1'b0);
    step(32'd0, 32'd0, 1'b1, 1'b0);
    check("min_result", result, 64'hFFFF_FFFF_8000_0000);
    check("min_ovf", {63'd0, overflow}, 64'd0);

    for (int i = 0; i < 12; i++) step(rand_op(), rand_op(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  step(rand_op(), rand_op(), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(rand_op(), rand_op(), 1'b1, 1'b0);

    step(rand_op(), rand_op(), 1'b1, 1'b1);
    check("midrst_result", result, 64'd0);
    step(32'd7, 32'd9, 1'b1, 1'b0);
    check("post_rst_first", result, 64'd0);
    step(rand_op(), rand_op(), 1'b1, 1'b0);
    check("post_rst_land", result, 64'd63);

    for (int i = 0; i < 300; i++)
      step(rand_op(), rand_op(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
